unsigned_div: RTL and testbench

Sequential restoring divider for the UART hex calculator ALU. It is the inverse operation of the shift-add multiplier.
- Takes a WIDTH-bit unsigned dividend and divisor when the parser signals `parser_done`.
- Runs one quotient bit per clock.
- Presents `{remainder, quotient}` on `result` for exactly one cycle, together with `alu_done`.
- Sits beside the multiplier behind the operator select; its outputs feed the result formatter and the UART TX path.

---
 rtl/unsigned_div_if.sv | 34 +++
 rtl/unsigned_div.sv | 153 +++++++++++++++
 tb/tb_unsigned_div.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/unsigned_div_if.sv
// Operand/result bundle between the operator select and the sequential divider.
interface unsigned_div_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               parser_done;
    logic [2*WIDTH-1:0] result;
    logic               alu_done;
    logic               busy;
    logic               div_zero;

    // Requester side: the parser/operator select
    modport master (
        output A,
        output B,
        output parser_done,
        input  result,
        input  alu_done,
        input  busy,
        input  div_zero
    );

    // Divider side
    modport slave (
        input  A,
        input  B,
        input  parser_done,
        output result,
        output alu_done,
        output busy,
        output div_zero
    );
endinterface

// File: rtl/unsigned_div.sv
// Sequential restoring divider: one quotient bit per clock, {remainder, quotient}
// presented for a single cycle with alu_done.
// Optional feature macro: UNSIGNED_DIV_ZERO_CHECK_EN (zero divisor short-cuts to DONE
// with result=0 and div_zero=1; when undefined div_zero is tied low).
module unsigned_div #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         n_rst,
    unsigned_div_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RES_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               alu_done_q, alu_done_d;
    logic               busy_q, busy_d;
`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
    logic               div_zero_q, div_zero_d;
`endif

    logic [WIDTH:0]     part_rem;
    logic [WIDTH:0]     trial;
    logic               borrow;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        part_rem = {r_q, q_q[WIDTH-1]};
        trial    = part_rem - {1'b0, d_q};
        borrow   = trial[WIDTH];
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers, loaded from the decoded next state so they never see the inputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result_q   <= '0;
            alu_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            result_q   <= result_d;
            alu_done_q <= alu_done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
    // Zero-divisor flag register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= div_zero_d;
        end
    end
`endif

    // Next-state, iteration datapath and output decode
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        q_d        = q_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        result_d   = '0;
        alu_done_d = 1'b0;
        busy_d     = 1'b0;
`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
        div_zero_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.parser_done) begin
                    r_d     = '0;
                    q_d     = bus.A;
                    d_d     = bus.B;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
                    if (bus.B == '0) begin
                        state_d    = DONE;
                        div_zero_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                // Restore on borrow, otherwise keep the difference and shift in a 1
                r_d   = borrow ? part_rem[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        alu_done_d = (state_d == DONE);
        if (state_d == DONE) begin
            result_d = {r_d, q_d};
        end
`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
        if (div_zero_d) begin
            result_d = '0;
        end
`endif
    end

    assign bus.result   = result_q;
    assign bus.alu_done = alu_done_q;
    assign bus.busy     = busy_q;
`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_unsigned_div.sv
// Scoreboard bench for unsigned_div (WIDTH=16).
module tb_unsigned_div;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [31:0] res;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;
    int   n_exp  = 0;
    exp_t sb[$];
    exp_t e;

    unsigned_div_if #(.WIDTH(W)) bus ();

    unsigned_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent reference: behavioural divide, with the zero-divisor convention
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        r.acc = 0;
        if (b == 16'd0) begin
`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
            r.res = 32'd0; r.dz = 1'b1; r.lat = 0;
`else
            r.res = {a, 16'hFFFF}; r.dz = 1'b0; r.lat = 16;
`endif
        end else begin
            r.res = {a % b, a / b}; r.dz = 1'b0; r.lat = 16;
        end
        return r;
    endfunction

    // Drive a one-cycle start pulse and register its expectation
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input exp_t x);
        exp_t t;
        t = x;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.parser_done = 1'b1;
        t.acc = cyc + 1;
        sb.push_back(t);
        n_exp++;
        @(posedge clk);
        #1;
        bus.parser_done = 1'b0;
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && bus.busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("timeout_idle", 64'(sb.size()), 64'd0);
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic dz, input int lat);
        exp_t r;
        r.res = res; r.dz = dz; r.acc = 0; r.lat = lat;
        return r;
    endfunction

    // Monitor: every cycle, idle outputs are zero; a done cycle pops and checks one entry
    always begin
        @(posedge clk);
        #1;
        if (n_rst) begin
            if (bus.alu_done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(bus.result), 64'(e.res));
                    chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("busy_done", 64'(bus.busy), 64'd1);
                end
            end else begin
                chk("idle_result", 64'(bus.result), 64'd0);
                chk("idle_div_zero", 64'(bus.div_zero), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        bus.A = '0;
        bus.B = '0;
        bus.parser_done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_alu_done", 64'(bus.alu_done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic and edge operands
        start_op(16'd100, 16'd7, mk(32'h0002_000E, 1'b0, 16));
        wait_idle();
        start_op(16'hFFFF, 16'd1, mk(32'h0000_FFFF, 1'b0, 16));
        wait_idle();
        start_op(16'd5, 16'd10, mk(32'h0005_0000, 1'b0, 16));
        wait_idle();
        start_op(16'hFFFF, 16'hFFFF, mk(32'h0000_0001, 1'b0, 16));
        wait_idle();

        // Divide by zero
`ifdef UNSIGNED_DIV_ZERO_CHECK_EN
        start_op(16'h1234, 16'd0, mk(32'h0000_0000, 1'b1, 0));
`else
        start_op(16'h1234, 16'd0, mk(32'h1234_FFFF, 1'b0, 16));
`endif
        wait_idle();

        // Start while busy: extra pulses at cycles 5 and 17 are ignored
        start_op(16'd100, 16'd7, mk(32'h0002_000E, 1'b0, 16));
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.A = 16'd50; bus.B = 16'd5; bus.parser_done = 1'b1;
        @(posedge clk);
        #1;
        bus.parser_done = 1'b0;
        chk("busy_run", 64'(bus.busy), 64'd1);
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("done_cycle", 64'(bus.alu_done), 64'd1);
        bus.A = 16'd50; bus.B = 16'd5; bus.parser_done = 1'b1;
        @(posedge clk);
        #1;
        bus.parser_done = 1'b0;
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        wait_idle();

        // Reset mid-operation
        start_op(16'd100, 16'd7, mk(32'h0002_000E, 1'b0, 16));
        repeat (8) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("abort_result", 64'(bus.result), 64'd0);
        chk("abort_alu_done", 64'(bus.alu_done), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_div_zero", 64'(bus.div_zero), 64'd0);
        sb.delete();
        n_exp--;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        start_op(16'd9, 16'd3, mk(32'h0000_0003, 1'b0, 16));
        wait_idle();

        // Back-to-back: second start in the first idle cycle after DONE
        start_op(16'd100, 16'd7, mk(32'h0002_000E, 1'b0, 16));
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (bus.alu_done) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) chk("timeout_b2b", 64'd0, 64'd1);
        end
        @(posedge clk);
        start_op(16'd1000, 16'd33, mk(32'h000A_001E, 1'b0, 16));
        wait_idle();

        // Random operands against the behavioural model
        for (int k = 0; k < 10; k++) begin
            ra = 16'($urandom);
            rb = (k < 4) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            start_op(ra, rb, model(ra, rb));
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #2;
        chk("done_count", 64'(n_done), 64'(n_exp));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
